// File: rtl/cvxif_mac_responder.sv
// CV-X-IF coprocessor responder: custom-3 ADD/MAC/CLR, in-order pending queue, Latency-stage
// result pipeline with backpressure. Define CVXIF_MAC_RESP_PERF_EN to add perf counter ports.
module cvxif_mac_responder #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned IdWidth = 4,
    parameter int unsigned Depth   = 4,
    parameter int unsigned Latency = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               issue_valid_i,
    output logic               issue_ready_o,
    input  logic [31:0]        issue_instr_i,
    input  logic [IdWidth-1:0] issue_id_i,
    input  logic [XLEN-1:0]    issue_rs1_i,
    input  logic [XLEN-1:0]    issue_rs2_i,
    output logic               issue_accept_o,
    output logic               issue_writeback_o,
    input  logic               commit_valid_i,
    input  logic [IdWidth-1:0] commit_id_i,
    input  logic               commit_kill_i,
    output logic               result_valid_o,
    input  logic               result_ready_i,
    output logic [IdWidth-1:0] result_id_o,
    output logic [4:0]         result_rd_o,
    output logic [XLEN-1:0]    result_data_o,
    output logic               result_we_o,
    output logic               err_o
`ifdef CVXIF_MAC_RESP_PERF_EN
    ,
    output logic [31:0]        perf_accepted_o,
    output logic [31:0]        perf_killed_o,
    output logic [31:0]        perf_stall_o
`endif
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [1:0] OpAdd = 2'd0;
    localparam logic [1:0] OpMac = 2'd1;
    localparam logic [1:0] OpClr = 2'd2;

    // Entries in [rd_ptr, cmt_ptr) are committed but waiting on a stall; [cmt_ptr, wr_ptr) are not.
    logic [IdWidth-1:0] q_id_q   [Depth];
    logic [IdWidth-1:0] q_id_d   [Depth];
    logic [4:0]         q_rd_q   [Depth];
    logic [4:0]         q_rd_d   [Depth];
    logic [1:0]         q_op_q   [Depth];
    logic [1:0]         q_op_d   [Depth];
    logic [XLEN-1:0]    q_rs1_q  [Depth];
    logic [XLEN-1:0]    q_rs1_d  [Depth];
    logic [XLEN-1:0]    q_rs2_q  [Depth];
    logic [XLEN-1:0]    q_rs2_d  [Depth];
    logic               q_kill_q [Depth];
    logic               q_kill_d [Depth];
    logic [PtrW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cmt_ptr_q, cmt_ptr_d;
    logic [XLEN-1:0]    acc_q, acc_d;
    logic               err_q, err_d;

    logic               p_valid_q [Latency];
    logic               p_valid_d [Latency];
    logic [IdWidth-1:0] p_id_q    [Latency];
    logic [IdWidth-1:0] p_id_d    [Latency];
    logic [4:0]         p_rd_q    [Latency];
    logic [4:0]         p_rd_d    [Latency];
    logic [XLEN-1:0]    p_data_q  [Latency];
    logic [XLEN-1:0]    p_data_d  [Latency];

    logic [PtrW-1:0] wr_idx, rd_idx, cmt_idx;
    logic            full, head_cmtd, cmt_hit, stall, pop, exec, legal, enq;
    logic [1:0]      dec_op, x_op;
    logic [XLEN-1:0] x_res;
    logic            unused_instr;

    assign wr_idx  = wr_ptr_q[PtrW-1:0];
    assign rd_idx  = rd_ptr_q[PtrW-1:0];
    assign cmt_idx = cmt_ptr_q[PtrW-1:0];
    assign full    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) && (wr_idx == rd_idx);
    assign stall   = result_valid_o && !result_ready_i;

    assign dec_op       = issue_instr_i[13:12];
    assign legal        = (issue_instr_i[6:0] == 7'h7B) && (issue_instr_i[31:25] == 7'd0) &&
                          (issue_instr_i[14:12] <= 3'd2);
    assign unused_instr = ^issue_instr_i[24:15];

    assign issue_ready_o     = !full;
    assign issue_accept_o    = issue_valid_i && legal;
    assign issue_writeback_o = issue_valid_i && legal && (dec_op != OpClr);
    assign enq               = issue_valid_i && issue_ready_o && legal;

    assign head_cmtd = (rd_ptr_q != cmt_ptr_q);
    assign cmt_hit   = commit_valid_i && (cmt_ptr_q != wr_ptr_q) && (commit_id_i == q_id_q[cmt_idx]);

    // A commit landing on an uncommitted head retires in the same cycle; otherwise it is marked.
    always_comb begin
        pop  = 1'b0;
        exec = 1'b0;
        if (head_cmtd) begin
            pop  = q_kill_q[rd_idx] || !stall;
            exec = !q_kill_q[rd_idx] && !stall;
        end else if (cmt_hit) begin
            pop  = commit_kill_i || !stall;
            exec = !commit_kill_i && !stall;
        end
    end

    always_comb begin
        x_op  = q_op_q[rd_idx];
        x_res = '0;
        acc_d = acc_q;
        if (exec) begin
            case (x_op)
                OpAdd: x_res = q_rs1_q[rd_idx] + q_rs2_q[rd_idx];
                OpMac: begin
                    x_res = acc_q + q_rs1_q[rd_idx] * q_rs2_q[rd_idx];
                    acc_d = x_res;
                end
                default: acc_d = '0;
            endcase
        end
    end

    always_comb begin
        q_id_d   = q_id_q;
        q_rd_d   = q_rd_q;
        q_op_d   = q_op_q;
        q_rs1_d  = q_rs1_q;
        q_rs2_d  = q_rs2_q;
        q_kill_d = q_kill_q;
        if (enq) begin
            q_id_d[wr_idx]   = issue_id_i;
            q_rd_d[wr_idx]   = issue_instr_i[11:7];
            q_op_d[wr_idx]   = dec_op;
            q_rs1_d[wr_idx]  = issue_rs1_i;
            q_rs2_d[wr_idx]  = issue_rs2_i;
            q_kill_d[wr_idx] = 1'b0;
        end
        if (cmt_hit) begin
            q_kill_d[cmt_idx] = commit_kill_i;
        end
        wr_ptr_d  = wr_ptr_q + (PtrW + 1)'(enq);
        rd_ptr_d  = rd_ptr_q + (PtrW + 1)'(pop);
        cmt_ptr_d = cmt_ptr_q + (PtrW + 1)'(cmt_hit);
        err_d     = err_q || (commit_valid_i && !cmt_hit);
    end

    always_comb begin
        p_valid_d = p_valid_q;
        p_id_d    = p_id_q;
        p_rd_d    = p_rd_q;
        p_data_d  = p_data_q;
        if (!stall) begin
            p_valid_d[0] = exec && (x_op != OpClr);
            if (exec) begin
                p_id_d[0]   = q_id_q[rd_idx];
                p_rd_d[0]   = q_rd_q[rd_idx];
                p_data_d[0] = x_res;
            end
            for (int unsigned i = 1; i < Latency; i++) begin
                p_valid_d[i] = p_valid_q[i-1];
                p_id_d[i]    = p_id_q[i-1];
                p_rd_d[i]    = p_rd_q[i-1];
                p_data_d[i]  = p_data_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cmt_ptr_q <= '0;
            acc_q     <= '0;
            err_q     <= 1'b0;
            for (int unsigned i = 0; i < Depth; i++) begin
                q_id_q[i]   <= '0;
                q_rd_q[i]   <= '0;
                q_op_q[i]   <= '0;
                q_rs1_q[i]  <= '0;
                q_rs2_q[i]  <= '0;
                q_kill_q[i] <= 1'b0;
            end
            for (int unsigned i = 0; i < Latency; i++) begin
                p_valid_q[i] <= 1'b0;
                p_id_q[i]    <= '0;
                p_rd_q[i]    <= '0;
                p_data_q[i]  <= '0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cmt_ptr_q <= cmt_ptr_d;
            acc_q     <= acc_d;
            err_q     <= err_d;
            q_id_q    <= q_id_d;
            q_rd_q    <= q_rd_d;
            q_op_q    <= q_op_d;
            q_rs1_q   <= q_rs1_d;
            q_rs2_q   <= q_rs2_d;
            q_kill_q  <= q_kill_d;
            p_valid_q <= p_valid_d;
            p_id_q    <= p_id_d;
            p_rd_q    <= p_rd_d;
            p_data_q  <= p_data_d;
        end
    end

    assign result_valid_o = p_valid_q[Latency-1];
    assign result_we_o    = p_valid_q[Latency-1];
    assign result_id_o    = p_id_q[Latency-1];
    assign result_rd_o    = p_rd_q[Latency-1];
    assign result_data_o  = p_data_q[Latency-1];
    assign err_o          = err_q;

`ifdef CVXIF_MAC_RESP_PERF_EN
    logic [31:0] perf_acc_q, perf_acc_d, perf_kill_q, perf_kill_d, perf_stall_q, perf_stall_d;

    always_comb begin
        perf_acc_d   = perf_acc_q + 32'(enq);
        perf_kill_d  = perf_kill_q + 32'(cmt_hit && commit_kill_i);
        perf_stall_d = perf_stall_q + 32'(stall);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_acc_q   <= '0;
            perf_kill_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_acc_q   <= perf_acc_d;
            perf_kill_q  <= perf_kill_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_accepted_o = perf_acc_q;
    assign perf_killed_o   = perf_kill_q;
    assign perf_stall_o    = perf_stall_q;
`endif

endmodule

// File: tb/tb_cvxif_mac_responder.sv
// Self-checking bench for cvxif_mac_responder: directed scenarios plus randomized traffic
// scored against a transaction-level model (pending list, accumulator, expected results).
module tb_cvxif_mac_responder;
    localparam int Depth = 4;

    logic        clk_i;
    logic        rst_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [31:0] issue_instr_i;
    logic [3:0]  issue_id_i;
    logic [31:0] issue_rs1_i;
    logic [31:0] issue_rs2_i;
    logic        issue_accept_o;
    logic        issue_writeback_o;
    logic        commit_valid_i;
    logic [3:0]  commit_id_i;
    logic        commit_kill_i;
    logic        result_valid_o;
    logic        result_ready_i;
    logic [3:0]  result_id_o;
    logic [4:0]  result_rd_o;
    logic [31:0] result_data_o;
    logic        result_we_o;
    logic        err_o;

    cvxif_mac_responder dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .issue_valid_i     (issue_valid_i),
        .issue_ready_o     (issue_ready_o),
        .issue_instr_i     (issue_instr_i),
        .issue_id_i        (issue_id_i),
        .issue_rs1_i       (issue_rs1_i),
        .issue_rs2_i       (issue_rs2_i),
        .issue_accept_o    (issue_accept_o),
        .issue_writeback_o (issue_writeback_o),
        .commit_valid_i    (commit_valid_i),
        .commit_id_i       (commit_id_i),
        .commit_kill_i     (commit_kill_i),
        .result_valid_o    (result_valid_o),
        .result_ready_i    (result_ready_i),
        .result_id_o       (result_id_o),
        .result_rd_o       (result_rd_o),
        .result_data_o     (result_data_o),
        .result_we_o       (result_we_o),
        .err_o             (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [3:0]  id;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
    } ent_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [31:0] data;
    } res_t;

    ent_t        pend[$];
    res_t        expq[$];
    logic [31:0] macc;
    bit          exp_err;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
        return {7'd0, 10'd0, f3, rd, 7'h7B};
    endfunction

    // Commits always target the oldest uncommitted instruction; results follow commit order.
    task automatic model_commit(input logic [3:0] cid, input bit kill);
        ent_t e;
        res_t r;
        if (pend.size() == 0 || pend[0].id != cid) begin
            exp_err = 1'b1;
            return;
        end
        e = pend.pop_front();
        if (kill) return;
        if (e.f3 == 3'd0) begin
            r.data = e.a + e.b;
        end else if (e.f3 == 3'd1) begin
            macc   = macc + e.a * e.b;
            r.data = macc;
        end else begin
            macc = '0;
            return;
        end
        r.id = e.id;
        r.rd = e.rd;
        expq.push_back(r);
    endtask

    task automatic cycle(input bit di, input logic [31:0] instr, input logic [3:0] id,
                         input logic [31:0] a, input logic [31:0] b, input bit dc,
                         input logic [3:0] cid, input bit kill, input bit chk_rdy);
        bit   legal, fire, exp_rdy;
        ent_t e;
        issue_valid_i  = di;
        issue_instr_i  = instr;
        issue_id_i     = id;
        issue_rs1_i    = a;
        issue_rs2_i    = b;
        commit_valid_i = dc;
        commit_id_i    = cid;
        commit_kill_i  = kill;
        #1;
        legal   = (instr[6:0] == 7'h7B) && (instr[31:25] == 7'd0) && (instr[14:12] <= 3'd2);
        exp_rdy = (pend.size() < Depth);
        if (chk_rdy) check_eq("issue_ready", issue_ready_o, exp_rdy);
        fire = di && (chk_rdy ? exp_rdy : issue_ready_o);
        if (di) begin
            check_eq("accept", issue_accept_o, legal);
            check_eq("writeback", issue_writeback_o, legal && (instr[14:12] != 3'd2));
        end
        @(posedge clk_i);
        #1;
        if (dc) model_commit(cid, kill);
        if (fire && legal) begin
            e.id = id;
            e.f3 = instr[14:12];
            e.rd = instr[11:7];
            e.a  = a;
            e.b  = b;
            pend.push_back(e);
        end
        issue_valid_i  = 1'b0;
        commit_valid_i = 1'b0;
        check_eq("err", err_o, exp_err);
    endtask

    task automatic iss(input logic [31:0] instr, input logic [3:0] id, input logic [31:0] a,
                       input logic [31:0] b);
        cycle(1'b1, instr, id, a, b, 1'b0, 4'd0, 1'b0, 1'b1);
    endtask

    task automatic cmt(input logic [3:0] cid, input bit kill, input bit chk_rdy);
        cycle(1'b0, 32'd0, 4'd0, 32'd0, 32'd0, 1'b1, cid, kill, chk_rdy);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 32'd0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_i          = 1'b1;
        issue_valid_i  = 1'b0;
        commit_valid_i = 1'b0;
        pend.delete();
        expq.delete();
        macc    = '0;
        exp_err = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    // Scoreboard: every valid result must match the model's oldest expected beat and hold while stalled.
    bit          held = 1'b0;
    logic [3:0]  h_id;
    logic [4:0]  h_rd;
    logic [31:0] h_data;
    always @(negedge clk_i) begin
        if (rst_i) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check_eq("hold_valid", result_valid_o, 1'b1);
                check_eq("hold_id", result_id_o, h_id);
                check_eq("hold_rd", result_rd_o, h_rd);
                check_eq("hold_data", result_data_o, h_data);
            end
            if (result_valid_o) begin
                if (expq.size() == 0) begin
                    check_eq("unexpected_result", result_valid_o, 1'b0);
                end else begin
                    check_eq("res_id", result_id_o, expq[0].id);
                    check_eq("res_rd", result_rd_o, expq[0].rd);
                    check_eq("res_data", result_data_o, expq[0].data);
                    check_eq("res_we", result_we_o, 1'b1);
                    if (result_ready_i) void'(expq.pop_front());
                end
            end
            held   = result_valid_o && !result_ready_i;
            h_id   = result_id_o;
            h_rd   = result_rd_o;
            h_data = result_data_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0]  snap_id;
        logic [31:0] snap_data;
        logic [31:0] instr;
        bit          di, dc, kill;
        logic [3:0]  cid;

        issue_valid_i  = 1'b0;
        issue_instr_i  = '0;
        issue_id_i     = '0;
        issue_rs1_i    = '0;
        issue_rs2_i    = '0;
        commit_valid_i = 1'b0;
        commit_id_i    = '0;
        commit_kill_i  = 1'b0;
        result_ready_i = 1'b1;
        do_reset();

        check_eq("rst_ready", issue_ready_o, 1'b1);
        check_eq("rst_accept", issue_accept_o, 1'b0);
        check_eq("rst_wb", issue_writeback_o, 1'b0);
        check_eq("rst_valid", result_valid_o, 1'b0);
        check_eq("rst_id", result_id_o, 4'd0);
        check_eq("rst_rd", result_rd_o, 5'd0);
        check_eq("rst_data", result_data_o, 32'd0);
        check_eq("rst_we", result_we_o, 1'b0);
        check_eq("rst_err", err_o, 1'b0);

        // ADD with exact latency
        iss(mk(3'd0, 5'd10), 4'd3, 32'd5, 32'd7);
        cmt(4'd3, 1'b0, 1'b1);
        check_eq("add_early", result_valid_o, 1'b0);
        idle(1);
        check_eq("add_valid", result_valid_o, 1'b1);
        check_eq("add_id", result_id_o, 4'd3);
        check_eq("add_data", result_data_o, 32'd12);
        idle(2);

        // MAC chain with a killed entry
        iss(mk(3'd1, 5'd1), 4'd4, 32'd3, 32'd4);
        cmt(4'd4, 1'b0, 1'b1);
        iss(mk(3'd1, 5'd2), 4'd5, 32'd2, 32'd5);
        cmt(4'd5, 1'b0, 1'b1);
        iss(mk(3'd1, 5'd3), 4'd6, 32'd9, 32'd9);
        cmt(4'd6, 1'b1, 1'b1);
        iss(mk(3'd1, 5'd4), 4'd7, 32'd1, 32'd1);
        cmt(4'd7, 1'b0, 1'b1);
        idle(1);
        check_eq("mac_final", result_data_o, 32'd23);
        idle(2);

        // Illegal instruction
        iss(32'h0000_0013, 4'd8, 32'd1, 32'd1);
        idle(3);

        // Fill, blocked 5th issue, blocked issue during pop, ready returns next cycle
        for (int k = 0; k < 4; k++) iss(mk(3'd0, 5'(k)), 4'(k), 32'(k), 32'd100);
        iss(mk(3'd0, 5'd9), 4'd4, 32'd1, 32'd1);
        cycle(1'b1, mk(3'd0, 5'd9), 4'd5, 32'd1, 32'd1, 1'b1, 4'd0, 1'b0, 1'b1);
        cycle(1'b0, 32'd0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        for (int k = 1; k < 4; k++) cmt(4'(k), 1'b0, 1'b1);
        idle(4);
        check_eq("fill_drained", expq.size(), 0);

        // Backpressure
        result_ready_i = 1'b0;
        iss(mk(3'd0, 5'd11), 4'd1, 32'd10, 32'd20);
        iss(mk(3'd0, 5'd12), 4'd2, 32'd1, 32'd2);
        cmt(4'd1, 1'b0, 1'b0);
        cmt(4'd2, 1'b0, 1'b0);
        snap_id   = result_id_o;
        snap_data = result_data_o;
        for (int k = 0; k < 5; k++) begin
            check_eq("bp_valid", result_valid_o, 1'b1);
            check_eq("bp_id", result_id_o, 4'd1);
            check_eq("bp_data", result_data_o, 32'd30);
            check_eq("bp_stable", {result_id_o, result_data_o}, {snap_id, snap_data});
            idle(1);
        end
        result_ready_i = 1'b1;
        idle(3);
        check_eq("bp_drained", expq.size(), 0);

        // Commit ID mismatch sets a sticky error; head stays intact
        iss(mk(3'd0, 5'd13), 4'd2, 32'd4, 32'd4);
        cmt(4'd9, 1'b0, 1'b1);
        check_eq("err_set", err_o, 1'b1);
        cmt(4'd2, 1'b0, 1'b1);
        idle(1);
        check_eq("err_head_data", result_data_o, 32'd8);
        idle(2);
        check_eq("err_sticky", err_o, 1'b1);

        // Commit of an ID issued in the same cycle is an error
        do_reset();
        cycle(1'b1, mk(3'd0, 5'd1), 4'd5, 32'd1, 32'd1, 1'b1, 4'd5, 1'b0, 1'b1);
        check_eq("same_cycle_err", err_o, 1'b1);
        cmt(4'd5, 1'b0, 1'b1);
        idle(3);

        // Reset mid-operation discards in-flight work and clears the accumulator
        do_reset();
        iss(mk(3'd1, 5'd1), 4'd1, 32'd3, 32'd3);
        cmt(4'd1, 1'b0, 1'b1);
        idle(3);
        iss(mk(3'd1, 5'd2), 4'd2, 32'd2, 32'd2);
        cmt(4'd2, 1'b0, 1'b1);
        do_reset();
        idle(4);
        iss(mk(3'd1, 5'd3), 4'd3, 32'd1, 32'd1);
        cmt(4'd3, 1'b0, 1'b1);
        idle(1);
        check_eq("rst_acc_valid", result_valid_o, 1'b1);
        check_eq("rst_acc_data", result_data_o, 32'd1);
        idle(2);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            result_ready_i = ($urandom_range(0, 9) < 7);
            di    = ($urandom_range(0, 1) == 1);
            instr = mk(3'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 7) == 0) instr[31:25] = 7'h01;
            dc   = 1'b0;
            cid  = 4'd0;
            kill = ($urandom_range(0, 3) == 0);
            if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
                dc  = 1'b1;
                cid = pend[0].id;
            end
            cycle(di, instr, 4'($urandom_range(0, 15)), $urandom, $urandom, dc, cid, kill, 1'b0);
        end

        result_ready_i = 1'b1;
        for (int k = 0; k < 40 && pend.size() > 0; k++) cmt(pend[0].id, 1'b0, 1'b0);
        for (int k = 0; k < 30 && expq.size() > 0; k++) idle(1);
        check_eq("final_drained", expq.size(), 0);
        check_eq("final_pending", pend.size(), 0);
        check_eq("final_err", err_o, exp_err);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
